// File: rtl/ultrasonic_ranger_multi.sv
// ultrasonic_ranger_multi: round-robin HC-SR04 ranger with per-channel BCD distance, proximity flags and echo timeout
module ultrasonic_ranger_multi #(
  parameter int NUM_CH      = 2,
  parameter int TRIG_CYCLES = 500,
  parameter int SLOT_CYCLES = 3000000,
  parameter int TICK_CYCLES = 2940,
  parameter int MAX_CM      = 400,
  parameter int NEAR_CM     = 30,
  parameter int STOP_CM     = 10
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    echo,
  output logic [NUM_CH-1:0]    trig,
  output logic [16*NUM_CH-1:0] dist_bcd,
  output logic                 dist_valid,
  output logic [2:0]           dist_ch,
  output logic [NUM_CH-1:0]    has_obstruction,
  output logic [NUM_CH-1:0]    backward,
  output logic [NUM_CH-1:0]    timeout
);
  localparam int CW = $clog2(MAX_CM + 1);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] TRIG_LAST = SW'(TRIG_CYCLES - 1);
  localparam logic [SW-1:0] RISE_LIM  = SW'(MAX_CM * TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CM_MAX    = CW'(MAX_CM);
  localparam logic [CW-1:0] CM_NEAR   = CW'(NEAR_CM);
  localparam logic [CW-1:0] CM_STOP   = CW'(STOP_CM);
  localparam logic [2:0]    CH_LAST   = 3'(NUM_CH - 1);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP} state_t;
  state_t state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] cm_q, cm_d;
  logic [15:0] bcd_q, bcd_d;
  logic [NUM_CH-1:0] s1_q, s2_q, s3_q, trig_q, obs_q, bwd_q, tmo_q, ch_oh;
  logic [16*NUM_CH-1:0] dist_q;
  logic rise, fall, done_tmo;
  function automatic logic [15:0] bcd_inc(input logic [15:0] b);
    logic [15:0] r;
    logic c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
  assign ch_oh = NUM_CH'(1) << ch_q;
  assign rise  = |(s2_q & ~s3_q & ch_oh);
  assign fall  = |(~s2_q & s3_q & ch_oh);
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    slot_d   = (slot_q == SLOT_LAST) ? slot_q : slot_q + 1'b1;
    tick_d   = tick_q;
    cm_d     = cm_q;
    bcd_d    = bcd_q;
    done_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = TRIG;
        slot_d  = '0;
      end
      TRIG: state_d = (slot_q == TRIG_LAST) ? WAIT_RISE : TRIG;
      WAIT_RISE:
        if (rise) begin
          state_d = MEASURE;
          tick_d  = '0;
          cm_d    = '0;
          bcd_d   = '0;
        end else if (slot_q >= RISE_LIM) begin
          state_d  = DONE;
          done_tmo = 1'b1;
        end
      MEASURE:
        if (fall) state_d = DONE;
        else if (cm_q == CM_MAX) begin
          state_d  = DONE;
          done_tmo = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          cm_d   = cm_q + 1'b1;
          bcd_d  = bcd_inc(bcd_q);
        end else tick_d = tick_q + 1'b1;
      DONE: state_d = GAP;
      GAP:
        if (slot_q == SLOT_LAST) begin
          state_d = TRIG;
          slot_d  = '0;
          ch_d    = (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
        end
      default: state_d = IDLE;
    endcase
  end
  // results land on the edge into DONE so they are stable while dist_valid is high
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      slot_q  <= '0;
      tick_q  <= '0;
      cm_q    <= '0;
      bcd_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      trig_q  <= '0;
      obs_q   <= '0;
      bwd_q   <= '0;
      tmo_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      slot_q  <= slot_d;
      tick_q  <= tick_d;
      cm_q    <= cm_d;
      bcd_q   <= bcd_d;
      s1_q    <= echo;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      trig_q  <= (state_q == TRIG) ? ch_oh : '0;
      if (state_d == DONE) begin
        dist_q[16*ch_q +: 16] <= done_tmo ? 16'h9999 : bcd_q;
        tmo_q <= (tmo_q & ~ch_oh) | (done_tmo ? ch_oh : '0);
        obs_q <= (obs_q & ~ch_oh) | ((!done_tmo && cm_q < CM_NEAR) ? ch_oh : '0);
        bwd_q <= (bwd_q & ~ch_oh) | ((!done_tmo && cm_q < CM_STOP) ? ch_oh : '0);
      end
    end
  end
  assign trig            = trig_q;
  assign dist_bcd        = dist_q;
  assign dist_valid      = (state_q == DONE);
  assign dist_ch         = ch_q;
  assign has_obstruction = obs_q;
  assign backward        = bwd_q;
  assign timeout         = tmo_q;
endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// tb_ultrasonic_ranger_multi: scoreboard bench for the multi-channel ranger with shortened timing
module tb_ultrasonic_ranger_multi;
  localparam int NUM_CH = 2, TRIG = 5, SLOT = 3000, TICK = 10, MAXC = 200, NEAR = 30, STOP = 10;
  typedef struct {
    int ch;
    logic [15:0] bcd;
    logic obs, bwd, tmo, lat;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [NUM_CH-1:0] echo = '0, trig, has_obstruction, backward, timeout;
  logic [16*NUM_CH-1:0] dist_bcd;
  logic dist_valid;
  logic [2:0] dist_ch;
  int checks = 0, failures = 0, cyc = 0, last_drop = 0, last_rise = 0, exp_tch = 0;
  logic have_rise = 0;
  logic [NUM_CH-1:0] prev_trig = '0;
  exp_t sb[$];
  exp_t cur;
  logic [15:0] m_bcd[NUM_CH];
  logic m_obs[NUM_CH], m_bwd[NUM_CH], m_tmo[NUM_CH];
  ultrasonic_ranger_multi #(.NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG), .SLOT_CYCLES(SLOT), .TICK_CYCLES(TICK),
    .MAX_CM(MAXC), .NEAR_CM(NEAR), .STOP_CM(STOP)) dut (
    .clk_in(clk), .rst(rst), .echo(echo), .trig(trig), .dist_bcd(dist_bcd), .dist_valid(dist_valid),
    .dist_ch(dist_ch), .has_obstruction(has_obstruction), .backward(backward), .timeout(timeout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  task automatic push(input int ch, input int cm, input logic tmo, input logic lat);
    exp_t e;
    e.ch  = ch;
    e.tmo = tmo;
    e.lat = lat;
    e.bcd = tmo ? 16'h9999 : to_bcd(cm);
    e.obs = !tmo && cm < NEAR;
    e.bwd = !tmo && cm < STOP;
    sb.push_back(e);
  endtask
  task automatic clear_model();
    for (int k = 0; k < NUM_CH; k++) begin
      m_bcd[k] = '0;
      m_obs[k] = 0;
      m_bwd[k] = 0;
      m_tmo[k] = 0;
    end
  endtask
  task automatic wait_hi(input int ch);
    for (int n = 0; n < 2 * SLOT && !trig[ch]; n++) @(negedge clk);
    chk("trig_hi", 32'(trig[ch]), 1);
  endtask
  task automatic wait_lo(input int ch);
    for (int n = 0; n < 4 * TRIG && trig[ch]; n++) @(negedge clk);
    chk("trig_lo", 32'(trig[ch]), 0);
  endtask
  task automatic pulse(input int ch, input int w);
    echo[ch] = 1'b1;
    repeat (w) @(negedge clk);
    echo[ch] = 1'b0;
    last_drop = cyc;
  endtask
  task automatic run(input int ch, input int cm);
    wait_hi(ch);
    wait_lo(ch);
    repeat (20) @(negedge clk);
    push(ch, cm, 0, 1);
    pulse(ch, cm * TICK + 5);
  endtask
  task automatic chk_cleared();
    chk("rst_trig", 32'(trig), 0);
    chk("rst_bcd", 32'(dist_bcd), 0);
    chk("rst_valid", 32'(dist_valid), 0);
    chk("rst_ch", 32'(dist_ch), 0);
    chk("rst_obs", 32'(has_obstruction), 0);
    chk("rst_bwd", 32'(backward), 0);
    chk("rst_tmo", 32'(timeout), 0);
  endtask
  // trig order, width and rise-to-rise spacing
  always @(negedge clk) begin
    if (rst) begin
      have_rise = 0;
      exp_tch   = 0;
      prev_trig = '0;
    end else begin
      if (trig != prev_trig) begin
        if (trig != '0) begin
          chk("trig_order", 32'(trig), 32'(1) << exp_tch);
          if (have_rise) chk("trig_spacing", cyc - last_rise, SLOT);
          last_rise = cyc;
          have_rise = 1;
          exp_tch   = (exp_tch + 1) % NUM_CH;
        end else chk("trig_width", cyc - last_rise, TRIG);
      end
      prev_trig = trig;
    end
  end
  always @(negedge clk) begin
    if (!rst && dist_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(dist_valid), 0);
      else begin
        cur = sb.pop_front();
        chk("dist_ch", 32'(dist_ch), cur.ch);
        if (cur.lat) chk("latency", cyc - last_drop, 3);
        m_bcd[cur.ch] = cur.bcd;
        m_obs[cur.ch] = cur.obs;
        m_bwd[cur.ch] = cur.bwd;
        m_tmo[cur.ch] = cur.tmo;
        for (int k = 0; k < NUM_CH; k++) begin
          chk($sformatf("bcd%0d", k), 32'(dist_bcd[16*k +: 16]), 32'(m_bcd[k]));
          chk($sformatf("obs%0d", k), 32'(has_obstruction[k]), 32'(m_obs[k]));
          chk($sformatf("bwd%0d", k), 32'(backward[k]), 32'(m_bwd[k]));
          chk($sformatf("tmo%0d", k), 32'(timeout[k]), 32'(m_tmo[k]));
        end
      end
    end
  end
  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared();
    rst = 0;
    @(posedge clk);
    #1 chk("t1_trig_1", 32'(trig), 0);
    @(posedge clk);
    #1 chk("t1_trig_2", 32'(trig), 1);
    run(0, 20);
    wait_hi(1);
    push(1, 0, 1, 0);
    run(0, 5);
    wait_hi(1);
    wait_lo(1);
    echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    push(1, 123, 0, 1);
    pulse(1, 123 * TICK + 5);
    echo[0] = 1'b0;
    run(0, 9);
    run(1, 10);
    run(0, 29);
    run(1, 30);
    wait_hi(0);
    wait_lo(0);
    repeat (20) @(negedge clk);
    push(0, 0, 1, 0);
    pulse(0, 205 * TICK + 5);
    wait_hi(1);
    echo[1] = 1'b1;
    wait_lo(1);
    repeat (50) @(negedge clk);
    echo[1] = 1'b0;
    repeat (10) @(negedge clk);
    push(1, 7, 0, 1);
    pulse(1, 7 * TICK + 5);
    wait_hi(0);
    wait_lo(0);
    repeat (20) @(negedge clk);
    echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    echo[0] = 1'b0;
    chk_cleared();
    clear_model();
    rst = 0;
    run(0, 42);
    run(1, 3);
    repeat (50) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
